// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - register map, status bit positions and FSM encodings
package mmio_uart_tx_pkg;
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;
  localparam int CTRL_OVF_CLR   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop shares the edge
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with a transmit FIFO
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h80000000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [63:0] data,
  input  logic [31:0] address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [1:0]  size,
  output logic        tx,
  output logic        irq
);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  uart_state_t   state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          tx_next, irq_next, ovf, pop, last_tick;
  logic          sel, push_req, ctrl_wr, full, empty;
  logic [3:0]    offset, count4;
  logic [7:0]    pop_data;
  logic [CW-1:0] fifo_count;
  logic [63:0]   status, rdata;
  logic          unused_bits;

  assign sel      = (address[31:4] == BASE_ADDR[31:4]);
  assign offset   = address[3:0];
  assign push_req = write_enable && sel && (offset == OFF_TXDATA);
  assign ctrl_wr  = write_enable && sel && (offset == OFF_CTRL);
  assign count4   = 4'(fifo_count);

  always_comb begin
    status                 = '0;
    status[STAT_COUNT_LSB +: 4] = count4;
    status[STAT_OVF]       = ovf;
    status[STAT_BUSY]      = (state != ST_IDLE);
    status[STAT_EMPTY]     = empty;
    status[STAT_FULL]      = full;
  end

  assign rdata = (offset == OFF_STATUS) ? status : 64'b0;
  assign data  = (read_enable && !write_enable && sel) ? rdata : 64'bz;
  assign unused_bits = ^{size, data[63:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data (data[7:0]),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign last_tick = (baud == BW'(CLKS_PER_BIT - 1));

  // tx_next is the line level for the cycle that follows this edge.
  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = pop_data;
          state_next = ST_START;
          baud_next  = '0;
          tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (last_tick) begin
          state_next = ST_DATA;
          baud_next  = '0;
          bit_next   = 3'd0;
          tx_next    = shift[0];
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      ST_DATA: begin
        if (last_tick) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift[7:1]};
            tx_next    = shift[1];
          end
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      ST_STOP: begin
        if (last_tick) begin
          baud_next = '0;
          if (!empty) begin
            pop        = 1'b1;
            shift_next = pop_data;
            state_next = ST_START;
            tx_next    = 1'b0;
          end else begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          baud_next = baud + BW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Returning to IDLE implies nothing was popped, so the FIFO stays empty unless a push lands now.
    irq_next = (state_next == ST_IDLE) && empty && !push_req;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
      irq     <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      tx      <= tx_next;
      irq     <= irq_next;
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (ctrl_wr && data[CTRL_OVF_CLR]) ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - randomized bench with a frame-timeline reference model
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'h80000000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        write_enable, read_enable;
  logic [1:0]  size;
  logic [63:0] drv;
  logic        drv_en;
  wire  [63:0] data;
  logic        tx, irq;

  assign data = drv_en ? drv : 64'bz;
  always #5 clock = ~clock;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .data(data), .address(address),
    .write_enable(write_enable), .read_enable(read_enable), .size(size),
    .tx(tx), .irq(irq)
  );

  int errors = 0;
  int checks = 0;
  bit run = 0;

  // Model: pending bytes plus position inside the current frame (-1 when the line is idle).
  logic [7:0] q[$];
  int         pos = -1;
  logic [7:0] cur = 8'h00;
  logic       ovf = 1'b0;

  function automatic logic m_tx();
    int b;
    if (pos < 0) return 1'b1;
    b = pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  function automatic logic m_irq();
    return (q.size() == 0) && (pos < 0);
  endfunction

  function automatic logic [63:0] m_status();
    int n;
    n = q.size();
    return {56'b0, 4'(n), ovf, (pos >= 0), (n == 0), (n == DEPTH)};
  endfunction

  initial begin
    bit pop;
    int sz;
    logic [7:0] head;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        q.delete();
        pos = -1;
        ovf = 1'b0;
      end else begin
        sz  = q.size();
        pop = 1'b0;
        if (sz > 0 && (pos < 0 || pos == FRAME - 1)) begin
          pop  = 1'b1;
          head = q.pop_front();
        end
        if (write_enable && address[31:4] == BASE[31:4]) begin
          if (address[3:0] == 4'h0) begin
            if (sz < DEPTH || pop) q.push_back(drv[7:0]);
            else ovf = 1'b1;
          end else if (address[3:0] == 4'h8 && drv[3]) begin
            ovf = 1'b0;
          end
        end
        if (pop) begin
          pos = 0;
          cur = head;
        end else if (pos == FRAME - 1) pos = -1;
        else if (pos >= 0) pos++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (run) begin
        chk("tx", {63'b0, tx}, {63'b0, m_tx()});
        chk("irq", {63'b0, irq}, {63'b0, m_irq()});
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [63:0] v, input logic re);
    address = a; drv = v; drv_en = 1'b1; write_enable = 1'b1; read_enable = re;
    size = 2'($urandom_range(0, 3));
    @(negedge clock);
    write_enable = 1'b0; drv_en = 1'b0; read_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [63:0] v);
    address = a; read_enable = 1'b1; drv_en = 1'b0;
    #1 v = data;
    read_enable = 1'b0;
  endtask

  // Bench holds the bus at zero; any DUT drive shows up as a nonzero or unknown value.
  task automatic z_check(input string name, input logic [31:0] a, input logic re);
    address = a; read_enable = re; drv = 64'h0; drv_en = 1'b1;
    #1 chk(name, data, 64'h0);
    drv_en = 1'b0; read_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((q.size() != 0 || pos >= 0) && k < limit) begin
      @(negedge clock);
      k++;
    end
    if (k >= limit) begin
      checks++; errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", limit);
    end
  endtask

  task automatic wait_pos(input int p, input int limit);
    int k = 0;
    while (pos != p && k < limit) begin
      @(negedge clock);
      k++;
    end
    if (k >= limit) begin
      checks++; errors++;
      $display("FAIL wait_pos: position %0d, required %0d", pos, p);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    logic [9:0]  exp_frame;
    logic [3:0]  off;
    int          r;
    reset = 1'b0; address = '0; write_enable = 1'b0; read_enable = 1'b0;
    size = 2'b0; drv = '0; drv_en = 1'b0;
    repeat (3) @(negedge clock);
    run = 1;
    chk("reset_tx", {63'b0, tx}, 64'h1);
    chk("reset_irq", {63'b0, irq}, 64'h1);
    bus_read(BASE | 32'h8, v); chk("reset_status", v, 64'h02);
    reset = 1'b1;
    @(negedge clock);
    bus_read(BASE | 32'h8, v); chk("release_status", v, 64'h02);
    idle(10);

    // Single A5 frame against a hand-written bit pattern.
    exp_frame = 10'b1101001010;
    bus_write(BASE, 64'hA5, 1'b0);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clock);
      chk("frame_a5", {63'b0, tx}, {63'b0, exp_frame[k / CPB]});
    end
    @(negedge clock);
    chk("a5_end_tx", {63'b0, tx}, 64'h1);
    chk("a5_end_irq", {63'b0, irq}, 64'h1);

    // Three back-to-back pushes.
    for (int k = 0; k < 3; k++) bus_write(BASE, 64'($urandom_range(0, 255)), 1'b0);
    bus_read(BASE | 32'h8, v); chk("b2b_status", v, 64'h24);
    wait_idle(300);

    // Overflow while the first frame is in its data bits.
    bus_write(BASE, 64'h3C, 1'b0);
    idle(6);
    for (int k = 0; k < 9; k++) bus_write(BASE, 64'($urandom_range(0, 255)), 1'b0);
    bus_read(BASE | 32'h8, v); chk("ovf_status", v, 64'h8D);
    bus_write(BASE | 32'h8, 64'h8, 1'b0);
    bus_read(BASE | 32'h8, v); chk("ovf_cleared", v, 64'h85);
    z_check("z_read_disabled", BASE | 32'h8, 1'b0);
    z_check("z_outside", BASE + 32'h10, 1'b1);
    wait_idle(600);

    // Full FIFO with a push on the same edge the stop bit ends.
    for (int k = 0; k < 9; k++) bus_write(BASE, 64'($urandom_range(0, 255)), 1'b0);
    bus_read(BASE | 32'h8, v); chk("full_before", v, 64'h85);
    wait_pos(FRAME - 1, 100);
    bus_write(BASE, 64'h5A, 1'b0);
    bus_read(BASE | 32'h8, v); chk("full_pop_push", v, 64'h85);
    wait_idle(600);

    // Asynchronous reset in the middle of a frame with bytes still queued.
    bus_write(BASE, 64'h00, 1'b0);
    bus_write(BASE, 64'h11, 1'b0);
    bus_write(BASE, 64'h22, 1'b0);
    wait_pos(15, 100);
    chk("tx_before_reset", {63'b0, tx}, 64'h0);
    #2 reset = 1'b0;
    #1 chk("async_reset_tx", {63'b0, tx}, 64'h1);
    chk("async_reset_irq", {63'b0, irq}, 64'h1);
    @(negedge clock);
    reset = 1'b1;
    bus_read(BASE | 32'h8, v); chk("post_reset_status", v, 64'h02);
    idle(100);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      off = 4'($urandom_range(0, 15));
      case (r)
        0, 1, 2, 3: bus_write(BASE, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        4: bus_write(BASE | 32'h8, 64'($urandom_range(0, 15)), 1'b0);
        5: begin
          if (off == 4'h0 || off == 4'h8) off = 4'h4;
          bus_write(BASE | 32'(off), {$urandom, $urandom}, 1'b0);
        end
        6: bus_write(BASE + 32'h10 + 32'(off), {$urandom, $urandom}, 1'b0);
        7: begin
          bus_read(BASE | 32'h8, v);
          chk("rand_status", v, m_status());
        end
        8: begin
          bus_read(BASE | 32'(off), v);
          chk("rand_read", v, (off == 4'h8) ? m_status() : 64'h0);
        end
        default: begin
          if ($urandom_range(0, 1) == 1) z_check("rand_z_disabled", BASE | 32'h8, 1'b0);
          else z_check("rand_z_outside", BASE + 32'h18, 1'b1);
        end
      endcase
      idle($urandom_range(0, 12));
    end
    wait_idle(1000);
    bus_read(BASE | 32'h8, v); chk("final_status", v, m_status());
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'h80000000, base of the 16-byte register window.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (minimum 2).
REQ-003 Parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 data  inout  64  shared system data bus, driven only during a selected read, else high-Z.
REQ-007 address  input  32  system address bus.
REQ-008 write_enable  input  1  bus write strobe, sampled on rising clock edge.
REQ-009 read_enable  input  1  bus read strobe; combinational bus drive.
REQ-010 size  input  2  access size; ignored except as stated in REQ-014.
REQ-011 tx  output  1  serial output, 8N1, idle high.
REQ-012 irq  output  1  high while FIFO empty and transmitter idle.

Function
REQ-013 Select = address[31:4] == BASE_ADDR[31:4]; offset = address[3:0]; offsets other than 4'h0 and 4'h8 are ignored on write and read as zero.
REQ-014 Write at offset 0 (TXDATA): push data[7:0] into FIFO on the clock edge, for any size value.
REQ-015 Write at offset 0 while FIFO full: byte dropped, sticky OVF bit set; exception: if a pop occurs on the same edge, the push is accepted.
REQ-016 Write at offset 8 (CTRL) with data[3]=1 clears OVF; other bits ignored.
REQ-017 Read at offset 8 (STATUS) drives {56'b0, count[3:0], OVF, BUSY, EMPTY, FULL} on data, bits [7:4] count, bit3 OVF, bit2 BUSY, bit1 EMPTY, bit0 FULL.
REQ-018 Read at offset 0 returns 64'b0.
REQ-019 data is driven only when read_enable=1 and the window is selected; otherwise high-Z, including whenever write_enable=1.
REQ-020 FSM states IDLE, START, DATA, STOP; BUSY = (state != IDLE).
REQ-021 IDLE: if FIFO non-empty, pop head into shift register, go to START on that edge; tx registered low from that edge.
REQ-022 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-023 DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles, 3-bit bit index, then STOP.
REQ-024 STOP: tx=1 for CLKS_PER_BIT cycles; at end, if FIFO non-empty, pop and go directly to START (no idle gap), else IDLE.
REQ-025 Frame length exactly 10*CLKS_PER_BIT cycles; push into an empty idle block at edge N gives tx falling at edge N+1.
REQ-026 Baud counter counts 0..CLKS_PER_BIT-1, reloads to 0 on every state change.
REQ-027 Push and pop on the same edge: count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-028 tx, irq and all state are registered outputs; no combinational path from bus to tx.

Reset
REQ-029 reset low asynchronously forces state=IDLE, tx=1, FIFO empty (count=0), OVF=0, baud counter=0, bit index=0, irq=1.
REQ-030 Reset mid-frame aborts the frame immediately; queued bytes are discarded.
REQ-031 First transmission after reset release needs a push; nothing is transmitted spontaneously.

Structure
REQ-032 Shared package/include holds register offsets (TXDATA=4'h0, CTRL/STATUS=4'h8), STATUS bit positions and FSM state encodings.
REQ-033 One sub-module sync_fifo (width 8, depth FIFO_DEPTH, full/empty/count outputs); bus decode, FSM and shifter stay in mmio_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8, BASE_ADDR=32'h80000000)
REQ-034 Write 8'hA5 to 0x80000000 -> tx: 0 (4 clk), bits 1,0,1,0,0,1,0,1 (4 clk each), 1 (4 clk); total 40 cycles; irq returns to 1.
REQ-035 Push 3 bytes back-to-back -> three contiguous 40-cycle frames, no idle gap; STATUS count goes 2,1,0 at each pop (the first pop happens at the push after the first byte).
REQ-036 Hold transmitter in DATA of the first frame, push 9 more bytes -> FULL=1, 9th push dropped, OVF=1; CTRL write 0x8 -> OVF=0.
REQ-037 Read 0x80000008 with read_enable=1 -> data = status value; read_enable=0 or address 0x80000010 -> data all Z.
REQ-038 Assert reset at cycle 15 of a frame -> tx=1 same cycle (asynchronous), STATUS reads 0x02 after release, no further frames.
REQ-039 FIFO full with STOP ending on the same edge as a write -> byte accepted, count stays 8, OVF stays 0.
